// File: rtl/barrel_shifter_arbiter.sv
// barrel_shifter_arbiter: round-robin front end that shares one combinational barrel shifter.
// Optional BARREL_SHIFTER_ARB_STATS_EN adds o_op_count, a saturating response-handshake counter.
module barrel_shifter_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req_valid,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    input  logic [N_REQ*3-1:0]     i_req_ctrl,
    input  logic [N_REQ*SHW-1:0]   i_req_shift,
    output logic [WIDTH-1:0]       o_sh_data,
    output logic [2:0]             o_sh_ctrl,
    output logic [SHW-1:0]         o_sh_shift,
    input  logic [WIDTH-1:0]       i_sh_result,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [WIDTH-1:0]       o_rsp_data,
    output logic [IDW-1:0]         o_rsp_id,
    output logic                   o_rsp_err
`ifdef BARREL_SHIFTER_ARB_STATS_EN
    ,
    output logic [15:0]            o_op_count
`endif
);

    // state | meaning
    // IDLE  | nothing in flight; arbiter may accept
    // EXEC  | operands on the shifter; result captured at end of cycle
    // RESP  | response held until consumer ready; may accept next op on handshake
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cand;
    logic           cand_found;
    logic           grant_en;
    logic           accept;
    logic           rsp_hs;

    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!cand_found && i_req_valid[(int'(ptr) + i) % N_REQ]) begin
                cand       = IDW'((int'(ptr) + i) % N_REQ);
                cand_found = 1'b1;
            end
        end
    end

    assign grant_en = (state == IDLE) || ((state == RESP) && i_rsp_ready);
    assign accept   = grant_en && cand_found;
    assign rsp_hs   = (state == RESP) && i_rsp_ready;

    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[cand] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (i_rsp_ready) begin
                    state_nxt = accept ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ptr doubles as the id of the op in flight, so no separate id register is kept
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr         <= IDW'(N_REQ - 1);
            o_sh_data   <= '0;
            o_sh_ctrl   <= '0;
            o_sh_shift  <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_id    <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (rsp_hs) begin
                o_rsp_valid <= 1'b0;
            end
            if (accept) begin
                o_sh_data  <= i_req_data[int'(cand)*WIDTH +: WIDTH];
                o_sh_ctrl  <= i_req_ctrl[int'(cand)*3 +: 3];
                o_sh_shift <= i_req_shift[int'(cand)*SHW +: SHW];
                ptr        <= cand;
            end
            if (state == EXEC) begin
                o_rsp_data  <= i_sh_result;
                o_rsp_id    <= ptr;
                o_rsp_err   <= (o_sh_ctrl == 3'b101) || (o_sh_ctrl == 3'b111);
                o_rsp_valid <= 1'b1;
            end
        end
    end

`ifdef BARREL_SHIFTER_ARB_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_op_count <= '0;
        end else if (rsp_hs && (o_op_count != 16'hFFFF)) begin
            o_op_count <= o_op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Bench for barrel_shifter_arbiter with a behavioural shifter attached.
// Reference: transaction-level round-robin model plus expected-response queue.
`timescale 1ns/1ps
module tb_barrel_shifter_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int SHW = 4;
    localparam int IDW = 2;

    typedef struct {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic           e;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data;
    logic [N*3-1:0]   req_ctrl;
    logic [N*SHW-1:0] req_shift;
    logic [W-1:0]     sh_data;
    logic [2:0]       sh_ctrl;
    logic [SHW-1:0]   sh_shift;
    logic [W-1:0]     sh_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_err;
`ifdef BARREL_SHIFTER_ARB_STATS_EN
    logic [15:0]      op_count;
`endif

    int   errors = 0;
    int   checks = 0;
    int   ptr_model;
    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    barrel_shifter_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .i_req_ctrl  (req_ctrl),
        .i_req_shift (req_shift),
        .o_sh_data   (sh_data),
        .o_sh_ctrl   (sh_ctrl),
        .o_sh_shift  (sh_shift),
        .i_sh_result (sh_result),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .o_rsp_err   (rsp_err)
`ifdef BARREL_SHIFTER_ARB_STATS_EN
        ,
        .o_op_count  (op_count)
`endif
    );

    // Behavioural shifter: 000 shl, 001 shr, 010 sra, 011 ror, 100 rol, 110 bit-reverse, others pass
    function automatic logic [W-1:0] sh_model(logic [W-1:0] d, logic [2:0] c, logic [SHW-1:0] s);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        int             n;
        n  = int'(s) % W;
        dd = {d, d};
        case (c)
            3'b000: r = d << s;
            3'b001: r = d >> s;
            3'b010: r = W'($signed(d) >>> s);
            3'b011: begin dd = dd >> n; r = dd[W-1:0]; end
            3'b100: begin dd = dd << n; r = dd[2*W-1:W]; end
            3'b110: for (int i = 0; i < W; i++) r[i] = d[W-1-i];
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb sh_result = sh_model(sh_data, sh_ctrl, sh_shift);

    function automatic int next_winner(logic [N-1:0] mask, int p);
        for (int i = 1; i <= N; i++) begin
            if (mask[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic exp_t expect_for(int k);
        exp_t x;
        logic [2:0] c;
        c    = req_ctrl[k*3 +: 3];
        x.d  = sh_model(req_data[k*W +: W], c, req_shift[k*SHW +: SHW]);
        x.id = IDW'(k);
        x.e  = (c == 3'b101) || (c == 3'b111);
        return x;
    endfunction

    task automatic randomize_req(int k);
        req_data[k*W +: W]       = W'($urandom);
        req_ctrl[k*3 +: 3]       = 3'($urandom);
        req_shift[k*SHW +: SHW]  = SHW'($urandom);
    endtask

    task automatic reset_dut();
        i_rst_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_ctrl  = '0;
        req_shift = '0;
        rsp_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        ptr_model = N - 1;
    endtask

    task automatic test_reset();
        reset_dut();
        #4;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, sh_data, sh_ctrl, sh_shift} !== '0)
            begin errors++; $display("FAIL reset_outputs: ready=%b rsp_v=%b rsp_d=%h id=%0d err=%b sh=%h/%b/%h, required all zero",
                req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, sh_data, sh_ctrl, sh_shift); end
        req_valid = 4'b1010;
        #1 checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_ptr_1010: ready=%b required 0010", req_ready); end
        req_valid = 4'b1111;
        #1 checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr_1111: ready=%b required 0001", req_ready); end
        req_valid = 4'b1000;
        #1 checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL reset_ptr_1000: ready=%b required 1000", req_ready); end
        req_valid = '0;
        @(posedge i_clk); #1;
        #4 checks++;
        if ({req_ready, rsp_valid} !== '0) begin errors++; $display("FAIL idle_no_valid: ready=%b rsp_v=%b required 0", req_ready, rsp_valid); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_directed();
        int             tk[3] = '{1, 0, 3};
        logic [W-1:0]   td[3] = '{8'h96, 8'h80, 8'h3C};
        logic [2:0]     tc[3] = '{3'b011, 3'b010, 3'b101};
        logic [SHW-1:0] ts[3] = '{4'd3, 4'd2, 4'd5};
        logic [W-1:0]   te[3] = '{8'hD2, 8'hE0, 8'h3C};
        logic           tr[3] = '{1'b0, 1'b0, 1'b1};
        logic [N-1:0]   oh;
        reset_dut();
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            oh = '0; oh[tk[t]] = 1'b1;
            req_data[tk[t]*W +: W]      = td[t];
            req_ctrl[tk[t]*3 +: 3]      = tc[t];
            req_shift[tk[t]*SHW +: SHW] = ts[t];
            req_valid = oh;
            #4 checks++;
            if (req_ready !== oh) begin errors++; $display("FAIL dir%0d_ready: ready=%b required %b", t, req_ready, oh); end
            @(posedge i_clk); #1;
            req_valid = '0;
            #4 checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_rsp: rsp_v=%b required 0", t, rsp_valid); end
            @(posedge i_clk); #1;
            #4 checks++;
            if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, te[t], IDW'(tk[t]), tr[t]})
                begin errors++; $display("FAIL dir%0d_rsp: v=%b d=%h id=%0d err=%b required v=1 d=%h id=%0d err=%b",
                    t, rsp_valid, rsp_data, rsp_id, rsp_err, te[t], tk[t], tr[t]); end
            @(posedge i_clk); #1;
            #4 checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_rsp_drop: rsp_v=%b required 0", t, rsp_valid); end
            @(posedge i_clk); #1;
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        int           w;
        exp_t         x;
        reset_dut();
        for (int k = 0; k < N; k++) randomize_req(k);
        req_valid = '1;
        rsp_ready = 1'b1;
        w = 0;
        for (int c = 0; c <= 16; c++) begin
            #4;
            exp_rdy = '0;
            if (c % 2 == 0) begin
                w = next_winner('1, ptr_model);
                exp_rdy[w] = 1'b1;
            end
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c%0d: ready=%b required %b", c, req_ready, exp_rdy); end
            checks++;
            if (c >= 2 && c % 2 == 0) begin
                if (exp_q.size() == 0) begin errors++; $display("FAIL rr_queue c%0d: response model empty", c); end
                else begin
                    x = exp_q.pop_front();
                    if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, x.d, x.id, x.e})
                        begin errors++; $display("FAIL rr_rsp c%0d: v=%b d=%h id=%0d err=%b required v=1 d=%h id=%0d err=%b",
                            c, rsp_valid, rsp_data, rsp_id, rsp_err, x.d, x.id, x.e); end
                end
            end else if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rr_rsp_gap c%0d: rsp_v=%b required 0", c, rsp_valid);
            end
            @(posedge i_clk); #1;
            if (c % 2 == 0) begin
                exp_q.push_back(expect_for(w));
                ptr_model = w;
                randomize_req(w);
            end
        end
`ifdef BARREL_SHIFTER_ARB_STATS_EN
        checks++;
        if (op_count !== 16'd8) begin errors++; $display("FAIL op_count: count=%0d required 8", op_count); end
`endif
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t x;
        exp_t y;
        reset_dut();
        for (int k = 0; k < N; k++) randomize_req(k);
        req_valid = '1;
        #4 checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_grant: ready=%b required 0001", req_ready); end
        @(posedge i_clk); #1;
        x = expect_for(0);
        randomize_req(0);
        #4 checks++;
        if ({req_ready, rsp_valid} !== '0) begin errors++; $display("FAIL bp_exec: ready=%b rsp_v=%b required 0", req_ready, rsp_valid); end
        @(posedge i_clk); #1;
        for (int c = 0; c < 5; c++) begin
            #4 checks++;
            if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err} !== {4'b0000, 1'b1, x.d, x.id, x.e})
                begin errors++; $display("FAIL bp_hold%0d: ready=%b v=%b d=%h id=%0d err=%b required ready=0000 v=1 d=%h id=%0d err=%b",
                    c, req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, x.d, x.id, x.e); end
            @(posedge i_clk); #1;
        end
        rsp_ready = 1'b1;
        #4 checks++;
        if ({req_ready, rsp_valid, rsp_data} !== {4'b0010, 1'b1, x.d})
            begin errors++; $display("FAIL bp_release: ready=%b v=%b d=%h required ready=0010 v=1 d=%h", req_ready, rsp_valid, rsp_data, x.d); end
        @(posedge i_clk); #1;
        y = expect_for(1);
        req_valid = '0;
        #4 checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs: rsp_v=%b required 0", rsp_valid); end
        @(posedge i_clk); #1;
        #4 checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, y.d, y.id, y.e})
            begin errors++; $display("FAIL bp_next_rsp: v=%b d=%h id=%0d err=%b required v=1 d=%h id=%0d err=%b",
                rsp_valid, rsp_data, rsp_id, rsp_err, y.d, y.id, y.e); end
        @(posedge i_clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_exec();
        exp_t x;
        reset_dut();
        randomize_req(1);
        randomize_req(2);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        req_valid = '0;
        i_rst_n   = 1'b0;
        #1 checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, sh_data, sh_ctrl, sh_shift} !== '0)
            begin errors++; $display("FAIL rst_exec_outputs: ready=%b v=%b d=%h id=%0d err=%b sh=%h/%b/%h required all zero",
                req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, sh_data, sh_ctrl, sh_shift); end
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        req_valid = 4'b0100;
        #4 checks++;
        if ({req_ready, rsp_valid} !== {4'b0100, 1'b0}) begin errors++; $display("FAIL rst_exec_regrant: ready=%b v=%b required 0100 0", req_ready, rsp_valid); end
        @(posedge i_clk); #1;
        x = expect_for(2);
        req_valid = '0;
        #4 checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_ghost: rsp_v=%b required 0", rsp_valid); end
        @(posedge i_clk); #1;
        #4 checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, x.d, x.id, x.e})
            begin errors++; $display("FAIL rst_exec_rsp: v=%b d=%h id=%0d err=%b required v=1 d=%h id=%0d err=%b",
                rsp_valid, rsp_data, rsp_id, rsp_err, x.d, x.id, x.e); end
        @(posedge i_clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        logic [N-1:0] oh;
        int           w;
        int           stall;
        exp_t         x;
        reset_dut();
        for (int op = 0; op < 25; op++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
            for (int k = 0; k < N; k++) randomize_req(k);
            mask      = N'($urandom_range(1, (1 << N) - 1));
            req_valid = mask;
            rsp_ready = 1'b0;
            w  = next_winner(mask, ptr_model);
            oh = '0; oh[w] = 1'b1;
            #4 checks++;
            if (req_ready !== oh) begin errors++; $display("FAIL rnd%0d_ready: mask=%b ready=%b required %b", op, mask, req_ready, oh); end
            @(posedge i_clk); #1;
            x = expect_for(w);
            ptr_model = w;
            req_valid = '0;
            #4 checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_early: rsp_v=%b required 0", op, rsp_valid); end
            @(posedge i_clk); #1;
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                if (s == stall) rsp_ready = 1'b1;
                #4 checks++;
                if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, x.d, x.id, x.e})
                    begin errors++; $display("FAIL rnd%0d_rsp s%0d: v=%b d=%h id=%0d err=%b required v=1 d=%h id=%0d err=%b",
                        op, s, rsp_valid, rsp_data, rsp_id, rsp_err, x.d, x.id, x.e); end
                @(posedge i_clk); #1;
            end
            rsp_ready = 1'b0;
            #4 checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop: rsp_v=%b required 0", op, rsp_valid); end
            @(posedge i_clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
